axis_stream_demux: RTL

AXI4-Stream 1-to-M_COUNT demultiplexer. It steers whole frames from a single input to one of M_COUNT outputs. The route is chosen by `select`, sampled at each frame boundary. It sits directly upstream of the reconfigurable partitions in the stream-switch DFX plugin. Each output feeds a partition whose output then enters the frame-level AXI-Stream mux, so one routed frame returns on the same port index. Output is fully registered (two-entry skid), so ready paths are broken in both directions.

---
 rtl/axis_switch_pkg.sv | 16 +
 rtl/axis_skid_reg.sv | 79 +++++++
 rtl/axis_stream_demux.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/axis_switch_pkg.sv
// axis_switch_pkg: definitions shared by the frame-level stream demux and mux.
// Provides the frame FSM state encoding and the select-port width helper.
package axis_switch_pkg;

  // Frame tracking: idle between frames, in-frame from start until tlast accept.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_state_e;

  // Width of a port-select field for n ports; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// axis_skid_reg: two-entry (main + temp) output register for a one-hot steered
// stream. The valid vector is M_COUNT wide and at most one-hot; the ready of
// whichever output the main entry targets decides whether it drains.
// empty_o / drain_o let the upstream compute a registered ready one cycle ahead.
module axis_skid_reg #(
  parameter int M_COUNT = 4,
  parameter int PW      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [M_COUNT-1:0] in_valid_i,
  input  logic [PW-1:0]      in_data_i,
  output logic [M_COUNT-1:0] out_valid_o,
  output logic [PW-1:0]      out_data_o,
  input  logic [M_COUNT-1:0] out_ready_i,
  output logic               empty_o,
  output logic               drain_o
);

  logic [M_COUNT-1:0] m_valid_q, m_valid_d;
  logic [M_COUNT-1:0] t_valid_q, t_valid_d;
  logic [PW-1:0]      m_data_q, t_data_q;
  logic               in_to_main, in_to_temp, temp_to_main;
  logic               out_xfer;

  assign out_xfer    = |(m_valid_q & out_ready_i);
  assign empty_o     = (m_valid_q == '0) && (t_valid_q == '0);
  assign drain_o     = out_xfer;
  assign out_valid_o = m_valid_q;
  assign out_data_o  = m_data_q;

  // Route the incoming beat to main when main frees up, else park it in temp.
  // Temp always refills main first so beat order is preserved.
  always_comb begin
    m_valid_d    = m_valid_q;
    t_valid_d    = t_valid_q;
    in_to_main   = 1'b0;
    in_to_temp   = 1'b0;
    temp_to_main = 1'b0;
    if (out_xfer || (m_valid_q == '0)) begin
      if (t_valid_q != '0) begin
        m_valid_d    = t_valid_q;
        temp_to_main = 1'b1;
        t_valid_d    = in_valid_i;
        in_to_temp   = (in_valid_i != '0);
      end else begin
        m_valid_d  = in_valid_i;
        in_to_main = (in_valid_i != '0);
      end
    end else if (in_valid_i != '0) begin
      t_valid_d  = in_valid_i;
      in_to_temp = 1'b1;
    end
  end

  // Valid flags are the only reset state of the buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= '0;
      t_valid_q <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      t_valid_q <= t_valid_d;
    end
  end

  // Payload registers load only on a move; no reset needed.
  always_ff @(posedge clk) begin
    if (in_to_main) begin
      m_data_q <= in_data_i;
    end else if (temp_to_main) begin
      m_data_q <= t_data_q;
    end
    if (in_to_temp) begin
      t_data_q <= in_data_i;
    end
  end

endmodule

// File: rtl/axis_stream_demux.sv
// axis_stream_demux: AXI4-Stream 1-to-M_COUNT frame demultiplexer.
// The destination is sampled from `select` when a frame starts and held until
// its tlast beat is accepted. Input ready and all outputs are registered.
// Optional feature macro AXIS_DEMUX_DROP_EN adds the `drop` port; without it
// only an out-of-range `select` discards a frame.
module axis_stream_demux
  import axis_switch_pkg::*;
#(
  parameter int M_COUNT     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH  = (DATA_WIDTH + 7) / 8,
  parameter int ID_ENABLE   = 0,
  parameter int ID_WIDTH    = 8,
  parameter int DEST_ENABLE = 0,
  parameter int DEST_WIDTH  = 8,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                             clk,
  input  logic                             rst,

  input  logic [DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]            s_axis_tkeep,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [ID_WIDTH-1:0]              s_axis_tid,
  input  logic [DEST_WIDTH-1:0]            s_axis_tdest,
  input  logic [USER_WIDTH-1:0]            s_axis_tuser,

  output logic [M_COUNT*DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [M_COUNT*KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic [M_COUNT-1:0]               m_axis_tvalid,
  input  logic [M_COUNT-1:0]               m_axis_tready,
  output logic [M_COUNT-1:0]               m_axis_tlast,
  output logic [M_COUNT*ID_WIDTH-1:0]      m_axis_tid,
  output logic [M_COUNT*DEST_WIDTH-1:0]    m_axis_tdest,
  output logic [M_COUNT*USER_WIDTH-1:0]    m_axis_tuser,

  input  logic                             enable,
`ifdef AXIS_DEMUX_DROP_EN
  input  logic                             drop,
`endif
  input  logic [sel_width(M_COUNT)-1:0]    select
);

  localparam int SEL_W = sel_width(M_COUNT);
  localparam int PW    = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH + DEST_WIDTH + USER_WIDTH;
  localparam logic [M_COUNT-1:0] ONE_HOT0 = {{(M_COUNT-1){1'b0}}, 1'b1};

  frame_state_e       state_q;
  logic [SEL_W-1:0]   select_q;
  logic               drop_q;
  logic               s_tready_q;

  logic               drop_in;
  logic               sel_oor;
  logic               beat_acc;
  logic               frame_start, frame_end;
  logic               frame_d, drop_d, start_drop;
  logic               s_tready_d;
  logic               m_ready_early;

  logic [M_COUNT-1:0] int_valid;
  logic [PW-1:0]      int_data;
  logic [M_COUNT-1:0] out_valid;
  logic [PW-1:0]      out_data;
  logic               skid_empty, skid_drain;

  logic [DATA_WIDTH-1:0] o_data;
  logic [KEEP_WIDTH-1:0] o_keep;
  logic                  o_last;
  logic [ID_WIDTH-1:0]   o_id;
  logic [DEST_WIDTH-1:0] o_dest;
  logic [USER_WIDTH-1:0] o_user;

`ifdef AXIS_DEMUX_DROP_EN
  assign drop_in = drop;
`else
  assign drop_in = 1'b0;
`endif

  // A select naming a non-existent port discards the frame rather than misroute it.
  assign sel_oor     = (int'(select) >= M_COUNT);
  assign start_drop  = drop_in || sel_oor;

  assign beat_acc    = s_axis_tvalid && s_tready_q;
  // Starts are only considered from idle, so a tlast accept and a new start
  // never share a cycle; back-to-back frames get one idle cycle between them.
  assign frame_start = (state_q == ST_IDLE) && enable && s_axis_tvalid;
  assign frame_end   = (state_q == ST_FRAME) && beat_acc && s_axis_tlast;
  assign frame_d     = frame_start || ((state_q == ST_FRAME) && !frame_end);
  assign drop_d      = frame_start ? start_drop : (frame_end ? 1'b0 : drop_q);

  // Lookahead for the registered ready. Using the drain of whatever the skid is
  // holding (rather than the new port's ready) keeps a stalled tail of the
  // previous frame from letting the next frame overrun temp.
  assign m_ready_early = skid_drain || skid_empty;
  assign s_tready_d    = frame_d && (drop_d || m_ready_early);
  assign s_axis_tready = s_tready_q;

  // Frame FSM: latch route/drop at start, release at tlast; ready registered alongside.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      select_q   <= '0;
      drop_q     <= 1'b0;
      s_tready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (frame_start) begin
            state_q  <= ST_FRAME;
            select_q <= select;
            drop_q   <= start_drop;
          end
        end
        ST_FRAME: begin
          if (frame_end) begin
            state_q <= ST_IDLE;
            drop_q  <= 1'b0;
          end
        end
      endcase
      s_tready_q <= s_tready_d;
    end
  end

  // Accepted, non-dropped beats steer to the latched port as a one-hot valid.
  assign int_valid = (beat_acc && (state_q == ST_FRAME) && !drop_q) ?
                     (ONE_HOT0 << select_q) : '0;

  // Disabled sidebands are normalised here so the outputs need no muxing.
  assign int_data = {
    s_axis_tdata,
    (KEEP_ENABLE != 0) ? s_axis_tkeep : {KEEP_WIDTH{1'b1}},
    s_axis_tlast,
    (ID_ENABLE   != 0) ? s_axis_tid   : {ID_WIDTH{1'b0}},
    (DEST_ENABLE != 0) ? s_axis_tdest : {DEST_WIDTH{1'b0}},
    (USER_ENABLE != 0) ? s_axis_tuser : {USER_WIDTH{1'b0}}
  };

  axis_skid_reg #(
    .M_COUNT (M_COUNT),
    .PW      (PW)
  ) u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (int_valid),
    .in_data_i   (int_data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_ready_i (m_axis_tready),
    .empty_o     (skid_empty),
    .drain_o     (skid_drain)
  );

  assign {o_data, o_keep, o_last, o_id, o_dest, o_user} = out_data;
  assign m_axis_tvalid = out_valid;

  // Payload is replicated to every port; only tvalid distinguishes them.
  for (genvar i = 0; i < M_COUNT; i++) begin : g_out
    assign m_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH] = o_data;
    assign m_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH] = o_keep;
    assign m_axis_tlast[i]                          = o_last;
    assign m_axis_tid[i*ID_WIDTH +: ID_WIDTH]       = o_id;
    assign m_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH] = o_dest;
    assign m_axis_tuser[i*USER_WIDTH +: USER_WIDTH] = o_user;
  end

endmodule
